// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI target port: status bit layout and read values.
package spi_slave_pkg;
  localparam int ST_OVERFLOW = 15;
  localparam int ST_UNDERRUN = 14;
  localparam int ST_TXFULL   = 13;
  localparam int ST_TXEMPTY  = 12;
  localparam int RXCOUNT_W   = 12;
  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;
endpackage

// File: rtl/spi_slave_fifo.sv
// Synchronous byte FIFO, combinational head; push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module spi_slave_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 target with CPU-side RX/TX byte FIFOs; pins oversampled, 3-cycle pin-to-internal latency.
// reg_wait stalls TX writes while full. Optional end-of-frame irq: SPI_SLAVE_FRAME_IRQ_EN.
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int          RXDEPTH = 16,
  parameter int          TXDEPTH = 16,
  parameter logic [7:0]  FILL    = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        reg_dat_re,
  input  logic        reg_dat_we,
  input  logic        reg_stat_re,
  input  logic [31:0] reg_di,
  output logic [31:0] reg_do,
  output logic        reg_wait,
  output logic        irq
);
  localparam int RCW = $clog2(RXDEPTH) + 1;
  localparam int TCW = $clog2(TXDEPTH) + 1;

  logic [2:0] sck_q, cs_q, mosi_q;
  logic       sck_rise, sck_fall, cs_rise, cs_fall, armed;
  logic [2:0] bitcnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr, tx_byte, rx_din;
  logic       overflow, underrun;

  logic [7:0]     rx_head, tx_head;
  logic           rx_full, rx_empty, tx_full, tx_empty;
  logic [RCW-1:0] rx_count;
  logic [TCW-1:0] tx_count;

  logic frame_end, frame_start, shift_in, shift_out, boundary;
  logic tx_pop, stat_clr, ovf_set, und_set;
  logic unused_sig;

  // cs_q resets to "selected" so a low cs_n at release never looks like a new frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q    <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_rise  <= 1'b0;
      cs_fall  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sck_q    <= {sck_q[1:0], sck};
      cs_q     <= {cs_q[1:0], cs_n};
      mosi_q   <= {mosi_q[1:0], mosi};
      sck_rise <= sck_q[1] & ~sck_q[2];
      sck_fall <= ~sck_q[1] & sck_q[2];
      cs_rise  <= cs_q[1] & ~cs_q[2];
      cs_fall  <= ~cs_q[1] & cs_q[2];
      armed    <= armed | cs_q[1];
    end
  end

  assign frame_end   = cs_rise;
  assign frame_start = cs_fall & armed & ~cs_rise;
  assign shift_in    = sck_rise & miso_oe & ~cs_rise & ~cs_fall;
  assign shift_out   = sck_fall & miso_oe & ~cs_rise & ~cs_fall;
  assign boundary    = shift_in & (bitcnt == 3'd7);
  assign rx_din      = {rx_sr, mosi_q[2]};
  assign tx_pop      = frame_start | boundary;
  assign tx_byte     = tx_empty ? FILL : tx_head;
  assign ovf_set     = boundary & rx_full & ~reg_dat_re;
  assign und_set     = tx_pop & tx_empty;
  assign stat_clr    = reg_stat_re & ~reg_dat_re;
  assign reg_wait    = reg_dat_we & tx_full & ~tx_pop;
  assign unused_sig  = ^{reg_di[31:8], tx_count};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miso     <= 1'b1;
      miso_oe  <= 1'b0;
      bitcnt   <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overflow <= ovf_set | (overflow & ~stat_clr);
      underrun <= und_set | (underrun & ~stat_clr);
      if (frame_end) begin
        miso_oe <= 1'b0;
        miso    <= 1'b1;
        bitcnt  <= '0;
      end else if (frame_start) begin
        miso_oe <= 1'b1;
        bitcnt  <= '0;
        tx_sr   <= tx_byte;
        miso    <= tx_byte[7];
      end else begin
        if (shift_in) begin
          rx_sr  <= rx_din[6:0];
          bitcnt <= bitcnt + 3'd1;
          if (boundary) tx_sr <= tx_byte;
        end
        // The falling edge right after a byte boundary presents the preloaded byte unshifted.
        if (shift_out) begin
          if (bitcnt != 3'd0) begin
            tx_sr <= tx_sr << 1;
            miso  <= tx_sr[6];
          end else begin
            miso  <= tx_sr[7];
          end
        end
      end
    end
  end

  spi_slave_fifo #(.DEPTH(RXDEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(boundary), .pop(reg_dat_re), .din(rx_din),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  spi_slave_fifo #(.DEPTH(TXDEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(reg_dat_we), .pop(tx_pop), .din(reg_di[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  always_comb begin
    reg_do = '0;
    if (reg_dat_re) begin
      reg_do = rx_empty ? EMPTY_READ : {24'b0, rx_head};
    end else if (reg_stat_re) begin
      reg_do[ST_OVERFLOW]     = overflow;
      reg_do[ST_UNDERRUN]     = underrun;
      reg_do[ST_TXFULL]       = tx_full;
      reg_do[ST_TXEMPTY]      = tx_empty;
      reg_do[RXCOUNT_W-1:0]   = RXCOUNT_W'(rx_count);
    end
  end

`ifdef SPI_SLAVE_FRAME_IRQ_EN
  logic got_byte;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      got_byte <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= frame_end & miso_oe & got_byte;
      if (frame_end | frame_start) got_byte <= 1'b0;
      else if (boundary)           got_byte <= 1'b1;
    end
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: queue model of both FIFOs and sticky flags, directed SPI frames.
`timescale 1ns/1ps
module tb_spi_slave_port;
  localparam int DEPTH = 16;
  localparam int HP    = 8;

  logic clk = 1'b0, resetn = 1'b0, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic reg_dat_re = 1'b0, reg_dat_we = 1'b0, reg_stat_re = 1'b0;
  logic [31:0] reg_di = '0;
  logic miso, miso_oe, reg_wait, irq;
  logic [31:0] reg_do;

  int checks = 0, errors = 0;
  int cyc = 0, cs_rise_cyc = 0, irq_cnt = 0, irq_lat = 0;
  logic irq_d = 1'b0;

  logic [7:0]  tx_q[$], rx_q[$];
  logic        m_ovf = 1'b0, m_und = 1'b0;
  logic [7:0]  mbuf [0:31];
  logic [7:0]  mrx  [0:31];
  logic [31:0] exp_do = '0;
  logic [31:0] v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_port dut (
    .clk(clk), .resetn(resetn), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_dat_re(reg_dat_re), .reg_dat_we(reg_dat_we),
    .reg_stat_re(reg_stat_re), .reg_di(reg_di), .reg_do(reg_do), .reg_wait(reg_wait), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---- model ----
  function automatic logic [7:0] m_tx_pop();
    if (tx_q.size() == 0) begin
      m_und = 1'b1;
      return 8'hFF;
    end
    return tx_q.pop_front();
  endfunction

  function automatic void m_byte_done(input logic [7:0] b);
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[15] = m_ovf;
    s[14] = m_und;
    s[13] = (tx_q.size() == DEPTH);
    s[12] = (tx_q.size() == 0);
    s[11:0] = 12'(rx_q.size());
    return s;
  endfunction

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (resetn) begin
      if (reg_dat_re || reg_stat_re) check("reg_do", reg_do, exp_do);
      else check("reg_do_idle", reg_do, 32'h0);
`ifdef SPI_SLAVE_FRAME_IRQ_EN
      if (irq) begin
        irq_cnt++;
        irq_lat = cyc - cs_rise_cyc;
        check("irq_width", irq_d, 0);
      end
      irq_d = irq;
`else
      check("irq_tied", irq, 0);
`endif
    end
  end

  // ---- CPU side ----
  task automatic cpu_read(output logic [31:0] act);
    exp_do = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;
    reg_dat_re = 1'b1;
    @(negedge clk);
    act = reg_do;
    tick(1);
    reg_dat_re = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
  endtask

  task automatic cpu_stat(output logic [31:0] act);
    exp_do = m_status();
    reg_stat_re = 1'b1;
    @(negedge clk);
    act = reg_do;
    tick(1);
    reg_stat_re = 1'b0;
    m_ovf = 1'b0;
    m_und = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] d, input int limit);
    logic ok;
    ok = 1'b0;
    reg_di = {24'h0, d};
    reg_dat_we = 1'b1;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (!reg_wait) ok = 1'b1;
    end
    tick(1);
    reg_dat_we = 1'b0;
    check("write_accept", ok, 1);
    if (ok) tx_q.push_back(d);
  endtask

  task automatic drain(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) cpu_read(t);
  endtask

  // ---- SPI master, mode 0, sck = clk/16 ----
  task automatic spi_frame(input int nbytes, input int tail_bits);
    logic [7:0] exp_b, got;
    int nb, total;
    total = nbytes + ((tail_bits > 0) ? 1 : 0);
    cs_n = 1'b0;
    exp_b = m_tx_pop();
    tick(HP);
    for (int i = 0; i < total; i++) begin
      nb = (i < nbytes) ? 8 : tail_bits;
      got = '0;
      for (int k = 7; k >= 8 - nb; k--) begin
        mosi = mbuf[i][k];
        tick(HP);
        sck = 1'b1;
        got = {got[6:0], miso};
        tick(HP);
        sck = 1'b0;
      end
      if (i < nbytes) begin
        mrx[i] = got;
        check("miso_byte", got, exp_b);
        check("miso_oe_active", miso_oe, 1);
        m_byte_done(mbuf[i]);
        exp_b = m_tx_pop();
      end
    end
    tick(HP);
    cs_n = 1'b1;
    cs_rise_cyc = cyc;
    tick(12);
    check("miso_oe_idle", miso_oe, 0);
    check("miso_idle", miso, 1);
  endtask

  initial begin
    tick(3);
    check("rst_miso", miso, 1);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_irq", irq, 0);
    check("rst_reg_wait", reg_wait, 0);
    check("rst_reg_do", reg_do, 32'h0);
    resetn = 1'b1;
    tick(4);

    // Basic exchange
    cpu_write(8'hA5, 50);
    cpu_write(8'h3C, 50);
    mbuf[0] = 8'h12; mbuf[1] = 8'h34;
    spi_frame(2, 0);
    check("t1_miso0", mrx[0], 8'hA5);
    check("t1_miso1", mrx[1], 8'h3C);
    cpu_read(v); check("t1_rd0", v, 32'h12);
    cpu_read(v); check("t1_rd1", v, 32'h34);
    cpu_read(v); check("t1_rd_empty", v, 32'hFFFF_FFFF);
    cpu_stat(v);

    // Underrun
    mbuf[0] = 8'h01; mbuf[1] = 8'h02; mbuf[2] = 8'h03;
    spi_frame(3, 0);
    for (int i = 0; i < 3; i++) check("t2_fill", mrx[i], 8'hFF);
    cpu_stat(v); check("t2_und_set", v[14], 1);
    cpu_stat(v); check("t2_und_clr", v[14], 0);
    drain(3);

    // Overflow
    for (int i = 0; i < 17; i++) mbuf[i] = 8'h40 + 8'(i);
    spi_frame(17, 0);
    cpu_stat(v);
    check("t3_ovf", v[15], 1);
    check("t3_rxcount", v[11:0], 16);
    cpu_read(v); check("t3_first", v, 32'h40);
    drain(14);
    cpu_read(v); check("t3_last", v, 32'h4F);
    cpu_read(v); check("t3_lost", v, 32'hFFFF_FFFF);
    cpu_stat(v);

    // Partial byte discarded
    mbuf[0] = 8'hF0;
    spi_frame(0, 5);
    cpu_stat(v); check("t4_rxcount", v[11:0], 0);
    mbuf[0] = 8'h81;
    spi_frame(1, 0);
    cpu_read(v); check("t4_rd", v, 32'h81);
    cpu_stat(v);

    // TX full with wait-stall
    for (int i = 0; i < 16; i++) cpu_write(8'hB0 + 8'(i), 50);
    cpu_stat(v); check("t5_txfull", v[13], 1);
    fork
      cpu_write(8'hC0, 3000);
      begin
        tick(40);
        check("t5_wait_held", reg_wait, 1);
        mbuf[0] = 8'h77;
        spi_frame(1, 0);
      end
    join
    check("t5_first", mrx[0], 8'hB0);
    cpu_read(v); check("t5_rd", v, 32'h77);
    for (int i = 0; i < 16; i++) mbuf[i] = 8'(i);
    spi_frame(16, 0);
    check("t5_order0", mrx[0], 8'hB2);
    check("t5_order14", mrx[14], 8'hC0);
    check("t5_order15", mrx[15], 8'hFF);
    drain(16);
    cpu_stat(v);

    // End-of-frame interrupt
    irq_cnt = 0;
    mbuf[0] = 8'h55; mbuf[1] = 8'hAA;
    spi_frame(2, 0);
`ifdef SPI_SLAVE_FRAME_IRQ_EN
    check("t6_irq_one", irq_cnt, 1);
    check("t6_irq_lat", (irq_lat <= 4) ? 1 : 0, 1);
`endif
    irq_cnt = 0;
    mbuf[0] = 8'hE0;
    spi_frame(0, 3);
    check("t6_irq_none", irq_cnt, 0);
    drain(2);
    cpu_stat(v);

    // Reset mid-frame, release with cs_n still low
    cpu_write(8'h99, 50);
    cs_n = 1'b0;
    tick(HP); sck = 1'b1; tick(HP); sck = 1'b0; tick(2);
    resetn = 1'b0;
    tx_q.delete(); rx_q.delete(); m_ovf = 1'b0; m_und = 1'b0;
    tick(3);
    check("t7_rst_oe", miso_oe, 0);
    check("t7_rst_miso", miso, 1);
    resetn = 1'b1;
    for (int b = 0; b < 8; b++) begin
      tick(HP); sck = 1'b1; tick(HP); sck = 1'b0;
    end
    check("t7_idle_oe", miso_oe, 0);
    cs_n = 1'b1;
    tick(12);
    cpu_stat(v); check("t7_rxcount", v[11:0], 0);
    mbuf[0] = 8'h5A;
    spi_frame(1, 0);
    check("t7_miso", mrx[0], 8'hFF);
    cpu_read(v); check("t7_rd", v, 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Memory-mapped SPI mode-0 target port for the picorv32 I/O system: the responder side of the SD/SPI master link. An external SPI master (companion MCU or a second FPGA) clocks bytes in and out while the CPU drains received bytes and queues reply bytes through simpleuart-style register strobes. Both directions are buffered in FIFOs, and all SPI pins are oversampled in the `clk` domain.

## Interface
- `RXDEPTH`, 16: receive FIFO depth in bytes; must be a power of 2, at least 2.
- `TXDEPTH`, 16: transmit FIFO depth in bytes; must be a power of 2, at least 2.
- `FILL`, 8'hFF: byte shifted out when the transmit FIFO is empty.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock from the master; CPOL=0, asynchronous to `clk`.
- `cs_n`  in  1  chip select from the master, active low; asynchronous to `clk`.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `miso_oe`  out  1  high while the frame is active; used for tristating `miso` externally.
- `reg_dat_re`  in  1  one-cycle strobe: read and pop one receive byte.
- `reg_dat_we`  in  1  write strobe: push `reg_di[7:0]` into the transmit FIFO.
- `reg_stat_re`  in  1  one-cycle strobe: read status and clear sticky flags.
- `reg_di`  in  32  write data.
- `reg_do`  out  32  read data; combinational.
- `reg_wait`  out  1  stall for `reg_dat_we` while the transmit FIFO is full.
- `irq`  out  1  end-of-frame pulse (see Configuration).

## Operation
- `sck`, `cs_n` and `mosi` each pass through a 2-FF synchronizer. Edges are detected on the synchronized `sck` and `cs_n`.
- Frame start (synchronized `cs_n` falls):
  - clear `bitcnt` (3 bits);
  - load the transmit shift register from the transmit FIFO head and pop it; if the FIFO is empty, load `FILL` and set sticky `UNDERRUN`;
  - drive `miso` with the shift register MSB;
  - assert `miso_oe`.
- Synchronized `sck` rising edge: shift `mosi` into the receive shift register (MSB first), then increment `bitcnt`.
- Synchronized `sck` falling edge with `bitcnt` != 0: shift the transmit register left and drive the new MSB.
- Byte boundary (rising edge that wraps `bitcnt` 7 to 0):
  - Push the completed receive byte into the receive FIFO. If the FIFO is full and not popped in the same cycle, drop the byte and set sticky `OVERFLOW`.
  - Preload the next transmit byte (FIFO pop, or `FILL` with `UNDERRUN`). It is driven on the following falling edge.
- Frame end (synchronized `cs_n` rises):
  - discard any partial byte and clear `bitcnt`;
  - deassert `miso_oe`;
  - set `miso` to 1;
  - the transmit FIFO contents are kept.
- `reg_dat_re`:
  - if the receive FIFO is non-empty, `reg_do` = {24'b0, head} and the head pops on this edge;
  - if it is empty, `reg_do` = 32'hFFFF_FFFF and nothing pops.
- `reg_stat_re`: `reg_do` = {16'b0, OVERFLOW, UNDERRUN, tx_full, tx_empty, rx_count[11:0]}. `OVERFLOW` and `UNDERRUN` clear on this edge; a same-cycle set wins over the clear.
- `reg_dat_we`:
  - pushes when the transmit FIFO is not full, or when it is popped in the same cycle;
  - otherwise `reg_wait` = 1 until space is available, and the push then occurs.
- If no strobe is active, `reg_do` = 0. `reg_dat_re` has priority over `reg_stat_re`.
- FIFO counts use one extra bit for the full/empty distinction. Pointers wrap modulo the depth.

## Timing
- Reset values: `miso`=1, `miso_oe`=0, `irq`=0, `reg_wait`=0, `reg_do`=0; FIFOs empty; flags clear.
- Pin-to-internal latency is 3 `clk` cycles (2-FF synchronizer plus edge register).
- The `miso` update lands 4 `clk` cycles after the pin-level falling edge of `sck`. The `sck` half-period must therefore be at least 5 `clk` cycles, so `sck` ≤ `clk`/10.
- The master must hold `cs_n` low for at least 5 `clk` cycles before the first `sck` rising edge.
- The receive byte is visible in `rx_count` 1 cycle after the synchronized 8th rising edge.
- Reset asserted mid-frame aborts immediately. After release, the port waits for a fresh `cs_n` falling edge; if `cs_n` is already low, it idles until `cs_n` rises.

## Configuration
- `SPI_SLAVE_FRAME_IRQ_EN` defined: `irq` pulses high for 1 cycle on every synchronized `cs_n` rising edge that ends a frame containing at least one complete byte.
- `SPI_SLAVE_FRAME_IRQ_EN` undefined: `irq` is tied to 0 and no frame-tracking logic is built.

## Structure
- Package `spi_slave_pkg` holds:
  - status bit positions: `ST_OVERFLOW`=15, `ST_UNDERRUN`=14, `ST_TXFULL`=13, `ST_TXEMPTY`=12;
  - the `RXCOUNT` field width (12);
  - the empty-read value 32'hFFFF_FFFF.
- Sub-module `spi_slave_fifo`: a synchronous byte FIFO with parameter `DEPTH`, ports push/pop/full/empty/count and a combinational head. It is instantiated once for receive and once for transmit.

## Test plan
- Reset, then CPU writes 0xA5 and 0x3C; master sends 0x12, 0x34 at `clk`/16 -> master receives 0xA5, 0x3C; two `reg_dat_re` return 0x12 then 0x34; a third returns 0xFFFF_FFFF.
- Transmit FIFO empty; master sends 3 bytes -> master receives 0xFF ×3; status read shows `UNDERRUN`=1; a second status read shows 0.
- Master sends 17 bytes with `RXDEPTH`=16 and no CPU reads -> `rx_count`=16, `OVERFLOW`=1, the 17th byte is lost; the first read returns byte 0.
- `cs_n` rises after 5 bits of 0xF0 -> nothing pushed, `rx_count`=0; the next frame sending 0x81 reads back 0x81.
- CPU writes 17 bytes with `TXDEPTH`=16 while the master is idle -> the 17th write holds `reg_wait`=1 until the master clocks one byte, then completes; the master sees the bytes in write order.
- With `SPI_SLAVE_FRAME_IRQ_EN` defined, a 2-byte frame -> one 1-cycle `irq` pulse within 4 cycles of `cs_n` rising; a frame of 0 complete bytes -> no pulse.
